// File: rtl/reset_sequencer.sv
// Lock-qualified reset release: periph -> mem -> core, with a filtered lock-loss re-assert.
// Optional define RSTSEQ_LOSS_CNT_EN adds an 8-bit saturating loss_cnt output.
//
// state      | meaning
// WAIT_LOCK  | all domains held, qualifying lock stability
// STG_PERIPH | peripherals released, gap before memory
// STG_MEM    | memory released, gap before core
// RUN        | all domains released, ready high
module reset_sequencer #(
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned STAGE_GAP     = 16,
    parameter int unsigned LOSS_FILTER   = 2,
    parameter int unsigned CNT_W         = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       locked,
    input  logic       soft_rst_req,
    output logic       n_rst_periph,
    output logic       n_rst_mem,
    output logic       n_rst_core,
    output logic       ready,
    output logic       lock_lost,
    output logic [1:0] state
`ifdef RSTSEQ_LOSS_CNT_EN
    ,
    output logic [7:0] loss_cnt
`endif
);

    typedef enum logic [1:0] {
        WAIT_LOCK  = 2'd0,
        STG_PERIPH = 2'd1,
        STG_MEM    = 2'd2,
        RUN        = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] GAP_TC    = CNT_W'(STAGE_GAP);
    localparam logic [CNT_W-1:0] LOSS_TC   = CNT_W'(LOSS_FILTER);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   stable_q, stable_d;
    logic [CNT_W-1:0]   gap_q, gap_d;
    logic [CNT_W-1:0]   low_q, low_d;
    logic               periph_q, periph_d;
    logic               mem_q, mem_d;
    logic               core_q, core_d;
    logic               ready_q, ready_d;
    logic               lost_q, lost_d;
    logic [CNT_W-1:0]   stable_inc, gap_inc, low_inc;
    logic               loss_fire;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign stable_inc = sat_inc(stable_q);
    assign gap_inc    = sat_inc(gap_q);
    assign low_inc    = sat_inc(low_q);
    assign loss_fire  = (state_q != WAIT_LOCK) && !locked && (low_inc == LOSS_TC);

    always_comb begin
        state_d  = state_q;
        stable_d = stable_q;
        gap_d    = gap_q;
        low_d    = low_q;
        periph_d = periph_q;
        mem_d    = mem_q;
        core_d   = core_q;
        ready_d  = ready_q;
        lost_d   = lost_q;

        if (state_q == WAIT_LOCK) begin
            low_d = '0;
            if (soft_rst_req) lost_d = 1'b0;
            if (!locked) begin
                stable_d = '0;
            end else begin
                stable_d = stable_inc;
                if (stable_inc == STABLE_TC) begin
                    periph_d = 1'b1;
                    gap_d    = '0;
                    state_d  = STG_PERIPH;
                end
            end
        end else if (loss_fire || soft_rst_req) begin
            // Lock loss takes priority so a coincident soft request still leaves lock_lost set.
            periph_d = 1'b0;
            mem_d    = 1'b0;
            core_d   = 1'b0;
            ready_d  = 1'b0;
            lost_d   = loss_fire;
            stable_d = '0;
            gap_d    = '0;
            low_d    = '0;
            state_d  = WAIT_LOCK;
        end else begin
            low_d = locked ? '0 : low_inc;
            case (state_q)
                STG_PERIPH: begin
                    gap_d = gap_inc;
                    if (gap_inc == GAP_TC) begin
                        mem_d   = 1'b1;
                        gap_d   = '0;
                        state_d = STG_MEM;
                    end
                end
                STG_MEM: begin
                    gap_d = gap_inc;
                    if (gap_inc == GAP_TC) begin
                        core_d  = 1'b1;
                        ready_d = 1'b1;
                        gap_d   = '0;
                        state_d = RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= WAIT_LOCK;
            stable_q <= '0;
            gap_q    <= '0;
            low_q    <= '0;
            periph_q <= 1'b0;
            mem_q    <= 1'b0;
            core_q   <= 1'b0;
            ready_q  <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            stable_q <= stable_d;
            gap_q    <= gap_d;
            low_q    <= low_d;
            periph_q <= periph_d;
            mem_q    <= mem_d;
            core_q   <= core_d;
            ready_q  <= ready_d;
            lost_q   <= lost_d;
        end
    end

`ifdef RSTSEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            loss_cnt_q <= 8'd0;
        end else if (loss_fire && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    assign loss_cnt = loss_cnt_q;
`endif

    assign n_rst_periph = periph_q;
    assign n_rst_mem    = mem_q;
    assign n_rst_core   = core_q;
    assign ready        = ready_q;
    assign lock_lost    = lost_q;
    assign state        = state_q;

endmodule
